mips_issue_queue: RTL and testbench



---
 rtl/mips_issue_queue.sv | 119 +++++++++++
 tb/tb_mips_issue_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_issue_queue.sv
// mips_issue_queue
//   Circular FIFO between a bursty producer and the MIPS execution stage.
//   It accepts {instruction, output_reg} pairs on a valid/ready handshake and
//   replays them as a registered, gap-free issue stream at one entry per
//   cycle. `hold` pauses issue without losing or skipping entries.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   producer handshake (in_ready = !full)
//   in_instruction      32-bit instruction word
//   in_output_reg       four 5-bit register selectors
//   hold                suppress issue at this edge
//   issue_valid         registered, drives MIPS in_valid
//   issue_instruction   registered, zero whenever issue_valid is 0
//   issue_output_reg    registered, zero whenever issue_valid is 0
//   count               registered occupancy
//   full, empty         decoded from count
//   issued_total        entries issued since reset, wraps at 16 bits
module mips_issue_queue #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instruction,
  input  logic [19:0]   in_output_reg,
  input  logic          hold,
  output logic          issue_valid,
  output logic [31:0]   issue_instruction,
  output logic [19:0]   issue_output_reg,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [15:0]   issued_total
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instruction;
    logic [19:0] output_reg;
  } entry_t;

  // Storage is not reset; contents only matter once count covers them.
  entry_t          mem_q [DEPTH];

  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            issue_valid_q, issue_valid_d;
  entry_t          issue_q, issue_d;
  logic [15:0]     issued_total_q, issued_total_d;

  logic            push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;

  // Pop never sees an entry pushed at the same edge: empty means no issue,
  // so there is no write-to-read bypass path.
  assign push = in_valid && in_ready;
  assign pop  = !hold && !empty;

  always_comb begin
    wp_d           = wp_q;
    rp_d           = rp_q;
    count_d        = count_q;
    issue_valid_d  = 1'b0;
    issue_d        = '0;   // payload is forced to zero when not issuing
    issued_total_d = issued_total_q;

    if (push) wp_d = wp_q + AW'(1);   // power-of-two depth: natural wrap

    if (pop) begin
      rp_d           = rp_q + AW'(1);
      issue_valid_d  = 1'b1;
      issue_d        = mem_q[rp_q];
      issued_total_d = issued_total_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q           <= '0;
      rp_q           <= '0;
      count_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_q        <= '0;
      issued_total_q <= '0;
    end else begin
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      count_q        <= count_d;
      issue_valid_q  <= issue_valid_d;
      issue_q        <= issue_d;
      issued_total_q <= issued_total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wp_q] <= '{instruction: in_instruction, output_reg: in_output_reg};
  end

  assign issue_valid       = issue_valid_q;
  assign issue_instruction = issue_q.instruction;
  assign issue_output_reg  = issue_q.output_reg;
  assign count             = count_q;
  assign issued_total      = issued_total_q;

endmodule

// File: tb/tb_mips_issue_queue.sv
// Bench for mips_issue_queue: directed stimulus pushes expected entries into
// a scoreboard queue; a negedge monitor pops and compares every issued entry
// and checks that idle cycles carry a zero payload.
module tb_mips_issue_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instruction;
  logic [19:0]   in_output_reg;
  logic          hold;
  logic          issue_valid;
  logic [31:0]   issue_instruction;
  logic [19:0]   issue_output_reg;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [15:0]   issued_total;

  mips_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_output_reg(in_output_reg),
    .hold(hold),
    .issue_valid(issue_valid), .issue_instruction(issue_instruction),
    .issue_output_reg(issue_output_reg),
    .count(count), .full(full), .empty(empty), .issued_total(issued_total)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [51:0] sb [$];
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; in_ready is stable until the next edge.
  task automatic offer(input logic [31:0] ins, input logic [19:0] oreg);
    in_valid       = 1'b1;
    in_instruction = ins;
    in_output_reg  = oreg;
    if (in_ready && rst_n) sb.push_back({ins, oreg});
  endtask

  task automatic idle();
    in_valid       = 1'b0;
    in_instruction = 32'hFFFF_FFFF;   // garbage that must be ignored
    in_output_reg  = 20'hFFFFF;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ivld"},  32'(issue_valid), 32'd0);
    chk({tag, "_iins"},  issue_instruction, 32'd0);
    chk({tag, "_ioreg"}, 32'(issue_output_reg), 32'd0);
    chk({tag, "_total"}, 32'(issued_total), 32'd0);
  endtask

  // Monitor: compares every issued entry against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (issue_valid) begin
        if (sb.size() == 0) begin
          chk("mon_unexpected_issue", issue_instruction, 32'hxxxx_xxxx);
        end else begin
          logic [51:0] e;
          e = sb.pop_front();
          chk("mon_ins",  issue_instruction, e[51:20]);
          chk("mon_oreg", 32'(issue_output_reg), 32'(e[19:0]));
        end
      end else begin
        chk("mon_idle_ins",  issue_instruction, 32'd0);
        chk("mon_idle_oreg", 32'(issue_output_reg), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    idle();
    #1;
    cyc(); cyc();
    chk_reset_state("rst");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single entry latency.
    offer(32'h2022_0005, 20'h0A418);
    cyc();                                  // edge 1
    idle();
    chk("t1_count1", 32'(count), 32'd1);
    cyc();                                  // edge 2
    chk("t1_vld", 32'(issue_valid), 32'd1);
    chk("t1_ins", issue_instruction, 32'h2022_0005);
    chk("t1_oreg", 32'(issue_output_reg), 32'h0A418);
    cyc();                                  // edge 3
    chk("t1_vld0", 32'(issue_valid), 32'd0);
    chk("t1_ins0", issue_instruction, 32'd0);
    chk("t1_total", 32'(issued_total), 32'd1);

    // Fill to full under hold, reject a 9th, then drain back-to-back.
    hold = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(32'(i), 20'(i));
      cyc();
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ready", 32'(in_ready), 32'd0);
    chk("t2_count", 32'(count), 32'd8);
    offer(32'h9, 20'h9);
    cyc();
    idle();
    chk("t2_count_after9", 32'(count), 32'd8);
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t2_drain_vld", 32'(issue_valid), 32'd1);
      chk("t2_drain_ins", issue_instruction, 32'(k + 1));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    cyc();
    chk("t2_after_vld", 32'(issue_valid), 32'd0);

    // Steady stream, one push per cycle; pointers wrap twice.
    for (int i = 0; i < 20; i++) begin
      offer(32'h100 + 32'(i), 20'(i * 3));
      cyc();
      chk("t3_cnt_le1", 32'(count <= 1), 32'd1);
      if (i >= 1) begin
        chk("t3_vld", 32'(issue_valid), 32'd1);
        chk("t3_ins", issue_instruction, 32'h100 + 32'(i - 1));
      end
    end
    idle();
    cyc();
    chk("t3_last", issue_instruction, 32'h113);
    cyc();
    chk("t3_end_vld", 32'(issue_valid), 32'd0);

    // Hold for 3 cycles mid-stream.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h200 + 32'(i), 20'h200 + 20'(i));
      cyc();
    end
    idle();
    hold = 1'b0;
    cyc();
    chk("t4_first", issue_instruction, 32'h200);
    chk("t4_cnt3", 32'(count), 32'd3);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_hold_vld", 32'(issue_valid), 32'd0);
      chk("t4_hold_ins", issue_instruction, 32'd0);
    end
    hold = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("t4_resume_vld", 32'(issue_valid), 32'd1);
      chk("t4_resume_ins", issue_instruction, 32'h200 + 32'(i));
    end
    cyc();
    chk("t4_empty", 32'(empty), 32'd1);

    // Reset mid-operation, with a push presented at the reset edge.
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer(32'h300 + 32'(i), 20'(i));
      cyc();
    end
    idle();
    hold = 1'b0;
    cyc();
    chk("t5_vld", 32'(issue_valid), 32'd1);
    chk("t5_cnt5", 32'(count), 32'd5);
    rst_n = 1'b0;
    offer(32'h5555_5555, 20'h55555);       // not recorded: rst_n is low
    cyc();
    sb.delete();
    idle();
    chk_reset_state("t5");
    rst_n = 1'b1;
    offer(32'hDEAD_BEEF, 20'h12345);
    cyc();
    idle();
    cyc();
    chk("t5_dead", issue_instruction, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) cyc();
    chk("t5_total", 32'(issued_total), 32'd1);
    chk("t5_empty", 32'(empty), 32'd1);

    // Wrap the 16-bit issue counter.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      offer(32'(i) * 32'h0100_0193 + 32'h1234, 20'(i * 7));
      cyc();
    end
    idle();
    cyc(); cyc();
    chk("t6_total", 32'(issued_total), 32'd1);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
